// File: rtl/fc_trigger_arbiter.sv
// fc_trigger_arbiter: L1A merge, prescale and veto stage for the fast-control path.
// Merges NUM_SRC single-cycle trigger sources. Each source has its own enable and prescale.
// The merged stream is gated by four vetoes: deadtime, DAQ busy, header-FIFO
// occupancy hysteresis and an optional token bucket.
// Optional feature: define FC_TRIG_TOKEN_BUCKET_EN to compile in the token-bucket
// rate limiter. When it is undefined, refill_period is ignored and veto_state[3] is 0.
module fc_trigger_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int PS_W    = 8,
  parameter int DT_W    = 12,
  parameter int OCC_W   = 8,
  parameter int CNT_W   = 16,
  parameter int BKT_W   = 4,
  parameter int BKT_MAX = 8
) (
  input  logic                     clk_bx,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       trig_in,
  input  logic [NUM_SRC-1:0]       src_enable,
  input  logic [NUM_SRC*PS_W-1:0]  prescale,
  input  logic [DT_W-1:0]          deadtime_len,
  input  logic                     busy_in,
  input  logic                     veto_busy_en,
  input  logic [OCC_W-1:0]         occupancy,
  input  logic [OCC_W-1:0]         occ_busy_thr,
  input  logic [OCC_W-1:0]         occ_ready_thr,
  input  logic                     veto_occ_en,
  input  logic [15:0]              refill_period,
  input  logic                     cnt_clear,
  output logic                     l1a,
  output logic [SRC_W-1:0]         l1a_src,
  output logic [31:0]              l1a_count,
  output logic [NUM_SRC*CNT_W-1:0] veto_count,
  output logic [3:0]               veto_state
);

  logic [NUM_SRC-1:0] pass;
  logic               veto;
  logic               accept;
  logic [SRC_W-1:0]   win_src;
  logic               l1a_q;
  logic [SRC_W-1:0]   l1a_src_q;
  logic [DT_W-1:0]    dt_cnt_q, dt_cnt_d;
  logic               busy_q;
  logic               occ_busy_q, occ_busy_d;
  logic [31:0]        l1a_count_q;
  logic [3:0]         veto_state_q;
  logic               bkt_empty, bkt_empty_d;

  // Per-source qualify, prescale counter and saturating vetoed-trigger counter.
  // The prescale counter advances on every qualified trigger, even vetoed ones.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic             qual;
    logic [PS_W-1:0]  ps_cnt_q;
    logic [CNT_W-1:0] vcnt_q;

    assign qual     = trig_in[gi] & src_enable[gi];
    assign pass[gi] = qual && (ps_cnt_q == prescale[gi*PS_W +: PS_W]);
    assign veto_count[gi*CNT_W +: CNT_W] = vcnt_q;

    // Prescale counter: wraps to 0 on the trigger it lets through.
    always_ff @(posedge clk_bx) begin
      if (reset)      ps_cnt_q <= '0;
      else if (qual)  ps_cnt_q <= pass[gi] ? '0 : ps_cnt_q + 1'b1;
    end

    // Vetoed-trigger counter: clear wins over increment, saturates at all-ones.
    always_ff @(posedge clk_bx) begin
      if (reset || cnt_clear)                    vcnt_q <= '0;
      else if (veto && pass[gi] && vcnt_q != '1) vcnt_q <= vcnt_q + 1'b1;
    end
  end

  // Lowest passing index wins; other passing sources merge into the same L1A.
  always_comb begin
    win_src = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pass[i]) win_src = SRC_W'(i);
    end
  end

`ifdef FC_TRIG_TOKEN_BUCKET_EN
  logic [15:0]      refill_cnt_q, refill_cnt_d;
  logic [BKT_W-1:0] tokens_q, tokens_d;
  logic             refill_wrap;

  // A refill_period of 0 switches the limiter off entirely.
  assign refill_wrap = (refill_period != 16'd0) && (refill_cnt_q >= refill_period - 16'd1);
  assign bkt_empty   = (tokens_q == '0) && (refill_period != 16'd0);

  // Next token count: a refill and a consume in the same cycle cancel out.
  always_comb begin
    refill_cnt_d = (refill_wrap || refill_period == 16'd0) ? 16'd0 : refill_cnt_q + 16'd1;
    tokens_d     = tokens_q;
    if (accept && !refill_wrap && tokens_q != '0)
      tokens_d = tokens_q - 1'b1;
    else if (!accept && refill_wrap && tokens_q < BKT_W'(BKT_MAX))
      tokens_d = tokens_q + 1'b1;
    bkt_empty_d = (tokens_d == '0) && (refill_period != 16'd0);
  end

  // Token bucket state; reset refills the bucket to capacity.
  always_ff @(posedge clk_bx) begin
    if (reset) begin
      refill_cnt_q <= '0;
      tokens_q     <= BKT_W'(BKT_MAX);
    end else begin
      refill_cnt_q <= refill_cnt_d;
      tokens_q     <= tokens_d;
    end
  end
`else
  logic unused_refill;
  assign unused_refill = ^refill_period;
  assign bkt_empty     = 1'b0;
  assign bkt_empty_d   = 1'b0;
`endif

  assign veto   = (dt_cnt_q != '0) | (busy_q & veto_busy_en) |
                  (occ_busy_q & veto_occ_en) | bkt_empty;
  assign accept = (|pass) & ~veto;

  // Deadtime reload on accept, else count down to zero; occupancy hysteresis.
  always_comb begin
    dt_cnt_d = accept ? deadtime_len : ((dt_cnt_q != '0) ? dt_cnt_q - 1'b1 : '0);
    if (occupancy >= occ_busy_thr)       occ_busy_d = 1'b1;
    else if (occupancy <= occ_ready_thr) occ_busy_d = 1'b0;
    else                                 occ_busy_d = occ_busy_q;
  end

  // Output pulse, veto state registers and the accepted-L1A counter.
  always_ff @(posedge clk_bx) begin
    if (reset) begin
      l1a_q        <= 1'b0;
      l1a_src_q    <= '0;
      dt_cnt_q     <= '0;
      busy_q       <= 1'b0;
      occ_busy_q   <= 1'b0;
      l1a_count_q  <= '0;
      veto_state_q <= '0;
    end else begin
      l1a_q        <= accept;
      if (accept) l1a_src_q <= win_src;
      dt_cnt_q     <= dt_cnt_d;
      busy_q       <= busy_in;
      occ_busy_q   <= occ_busy_d;
      veto_state_q <= {bkt_empty_d, occ_busy_d, busy_in, dt_cnt_d != '0};
      if (cnt_clear)                         l1a_count_q <= '0;
      else if (accept && l1a_count_q != '1)  l1a_count_q <= l1a_count_q + 32'd1;
    end
  end

  assign l1a        = l1a_q;
  assign l1a_src    = l1a_src_q;
  assign l1a_count  = l1a_count_q;
  assign veto_state = veto_state_q;

endmodule
